// File: rtl/ssd_scan_driver.sv
// Time-multiplexed driver for DIGITS active-low seven-segment digits on one shared segment bus.
// Holds a 5-bit code per digit; adds per-digit blinking, leading-zero blanking and a dead cycle per slot.
module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 125
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [4:0]        wr_code,
  input  logic [DIGITS-1:0] blink_mask,
  input  logic              lzb,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [4:0] CODE_BLANK = 5'd30;

  logic [PW-1:0]     pre;
  logic [IW-1:0]     idx;
  logic [FW-1:0]     frame;
  logic              phase;
  logic [4:0]        mem [DIGITS];

  logic              tick;
  logic              last_idx;
  logic              last_frame;
  logic              wr_ok;
  logic [DIGITS-1:0] suppress;
  logic [7:0]        seg_next;
  logic [DIGITS-1:0] an_next;

  function automatic logic [7:0] decode(input logic [4:0] code);
    logic [7:0] pat;
    case (code)
      5'd0, 5'd10, 5'd11: pat = 8'h03;
      5'd1, 5'd12:        pat = 8'h9F;
      5'd2, 5'd13:        pat = 8'h25;
      5'd3, 5'd14:        pat = 8'h0D;
      5'd4, 5'd15:        pat = 8'h99;
      5'd5, 5'd16:        pat = 8'h49;
      5'd6, 5'd17:        pat = 8'h41;
      5'd7, 5'd18:        pat = 8'h1F;
      5'd8, 5'd19:        pat = 8'h01;
      5'd9, 5'd20:        pat = 8'h09;
      5'd21:              pat = 8'h71; // F
      5'd22:              pat = 8'h11; // A
      5'd23:              pat = 8'hF3; // I
      5'd24:              pat = 8'hE3; // L
      5'd25:              pat = 8'h13; // N
      5'd26:              pat = 8'h83; // U
      5'd27:              pat = 8'h61; // E
      5'd28:              pat = 8'h85; // D
      default:            pat = 8'hFF;
    endcase
    // Dotted codes 11..20 reuse the digit pattern with dp lit.
    if (code >= 5'd11 && code <= 5'd20) pat[0] = 1'b0;
    return pat;
  endfunction

  assign tick       = (pre == PW'(REFRESH_DIV - 1));
  assign last_idx   = (idx == IW'(DIGITS - 1));
  assign last_frame = (frame == FW'(BLINK_DIV - 1));
  assign wr_ok      = wr_en && (32'(wr_addr) < 32'(DIGITS));

  // Walk from the most significant digit down; suppression continues only through zeros and blanks.
  always_comb begin
    logic            run;
    logic [4:0]      code;
    logic            is_zero;
    int unsigned     i;
    suppress = '0;
    run      = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      i       = DIGITS - 1 - k;
      code    = mem[IW'(i)];
      is_zero = (code == 5'd0) || (code == 5'd10);
      suppress[IW'(i)] = lzb && run && is_zero && (i != 0);
      run     = run && (is_zero || code >= 5'd29);
    end
  end

  always_comb begin
    seg_next = 8'hFF;
    an_next  = '1;
    if (!tick) begin
      an_next = ~(DIGITS'(1) << idx);
      if (!((phase && blink_mask[idx]) || suppress[idx]))
        seg_next = decode(mem[idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre   <= '0;
      idx   <= '0;
      frame <= '0;
      phase <= 1'b0;
      seg   <= '1;
      an    <= '1;
      for (int unsigned i = 0; i < DIGITS; i++) mem[IW'(i)] <= CODE_BLANK;
    end else begin
      if (wr_ok) mem[wr_addr[IW-1:0]] <= wr_code;
      if (tick) begin
        pre <= '0;
        idx <= last_idx ? '0 : idx + 1'b1;
        if (last_idx) begin
          frame <= last_frame ? '0 : frame + 1'b1;
          if (last_frame) phase <= ~phase;
        end
      end else begin
        pre <= pre + 1'b1;
      end
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomized bench for ssd_scan_driver; expected outputs come from a model that derives
// scan position and blink phase arithmetically from the cycle count since reset.
module tb_ssd_scan_driver;

  localparam int D = 4;
  localparam int R = 4;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [4:0]   wr_code;
  logic [D-1:0] blink_mask;
  logic         lzb;
  logic [7:0]   seg;
  logic [D-1:0] an;

  int           n_checks = 0;
  int           n_errors = 0;

  int           t;
  int           mem_m [D];
  logic [7:0]   seg_tab [32];
  logic [7:0]   exp_seg;
  logic [D-1:0] exp_an;

  ssd_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_code   (wr_code),
    .blink_mask(blink_mask),
    .lzb       (lzb),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, want);
    end
  endtask

  function automatic bit is_zero_code(input int c);
    return (c == 0) || (c == 10);
  endfunction

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int  idx;
    bit  blank;
    bit  above_ok;
    if (reset) begin
      exp_seg = 8'hFF;
      exp_an  = '1;
      t       = 0;
      for (int i = 0; i < D; i++) mem_m[i] = 30;
      return;
    end
    if ((t % R) == R - 1) begin
      exp_seg = 8'hFF;
      exp_an  = '1;
    end else begin
      idx    = (t / R) % D;
      exp_an = ~(D'(1) << idx);
      blank  = (((t / (R * D * B)) % 2) == 1) && blink_mask[idx];
      if (lzb && idx > 0 && is_zero_code(mem_m[idx])) begin
        above_ok = 1'b1;
        for (int j = idx + 1; j < D; j++)
          if (!(is_zero_code(mem_m[j]) || mem_m[j] >= 29)) above_ok = 1'b0;
        if (above_ok) blank = 1'b1;
      end
      exp_seg = blank ? 8'hFF : seg_tab[mem_m[idx]];
    end
    if (wr_en && wr_addr < D) mem_m[wr_addr] = wr_code;
    t++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("seg", seg, exp_seg);
    check("an", {4'b0, an}, {4'b0, exp_an});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int addr, input int code);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_code = 5'(code);
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    logic [7:0] digit_pat [10];
    digit_pat = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    for (int c = 0; c < 10; c++) begin
      seg_tab[c]      = digit_pat[c];
      seg_tab[c + 11] = digit_pat[c] & 8'hFE;
    end
    seg_tab[10] = digit_pat[0];
    seg_tab[21] = 8'h71; seg_tab[22] = 8'h11; seg_tab[23] = 8'hF3; seg_tab[24] = 8'hE3;
    seg_tab[25] = 8'h13; seg_tab[26] = 8'h83; seg_tab[27] = 8'h61; seg_tab[28] = 8'h85;
    seg_tab[29] = 8'hFF; seg_tab[30] = 8'hFF; seg_tab[31] = 8'hFF;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_code = '0; blink_mask = '0; lzb = 1'b0;
    t = 0;
    for (int i = 0; i < D; i++) mem_m[i] = 30;

    run(3);
    reset = 1'b0;
    run(40);

    wr(0, 1); wr(1, 2); wr(2, 19); wr(3, 21);
    run(20);

    wr(0, 5); wr(1, 0); wr(2, 0); wr(3, 0);
    lzb = 1'b1;
    run(20);
    wr(2, 11);
    run(20);

    lzb = 1'b0;
    wr(0, 8);
    blink_mask = 4'b0001;
    run(80);

    wr(5, 3);
    run(6);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(20);

    for (int n = 0; n < 600; n++) begin
      reset   = ($urandom_range(0, 199) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_code = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if ($urandom_range(0, 31) == 0) blink_mask = D'($urandom);
      step();
    end
    reset = 1'b0;
    wr_en = 1'b0;
    run(16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
